mem_port_arbiter: RTL and testbench

//  Shares the single-port unified memory between three requesters:
//    - instruction fetch (IF): feeds the IR, whose valid drives W_IR_valid into the controller
//    - data access (D): LDR/STR sequenced by the FSM
//    - debug/loader port (DBG)

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the unified-memory port arbiter
package mem_arb_pkg;

    // Access sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Requester identifiers
    typedef logic [1:0] req_id_t;
    localparam req_id_t REQ_D   = 2'd0;
    localparam req_id_t REQ_IF  = 2'd1;
    localparam req_id_t REQ_DBG = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - fixed-priority pick with debug starvation promotion
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int DBG_MAX = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_arb,
    input  logic    i_d_req,
    input  logic    i_if_req,
    input  logic    i_dbg_req,
    output req_id_t o_id,
    output logic    o_any
);

    localparam int CW = $clog2(DBG_MAX + 1);

    logic [CW-1:0] r_starv;
    logic          w_promote;

    assign w_promote = (r_starv == CW'(DBG_MAX)) && i_dbg_req;
    assign o_any     = i_d_req | i_if_req | i_dbg_req;

    // Winner: a starved debug port jumps the queue, otherwise D > IF > DBG
    always_comb begin
        o_id = REQ_D;
        if (w_promote)     o_id = REQ_DBG;
        else if (i_d_req)  o_id = REQ_D;
        else if (i_if_req) o_id = REQ_IF;
        else if (i_dbg_req) o_id = REQ_DBG;
    end

    // Count arbitrations the waiting debug port loses; saturate at DBG_MAX
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starv <= '0;
        end else if (!i_dbg_req) begin
            r_starv <= '0;
        end else if (i_arb && (o_id == REQ_DBG)) begin
            r_starv <= '0;
        end else if (i_arb && (r_starv != CW'(DBG_MAX))) begin
            r_starv <= r_starv + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises IF, D and DBG accesses onto one memory port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int DBG_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LW = $clog2(MEM_LAT + 1);

    logic [1:0]        r_state;
    req_id_t           r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [LW-1:0]     r_lat;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    req_id_t           w_id;
    logic              w_any;
    logic              w_idle;
    logic              w_issue;
    logic              w_resp;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_issue = (r_state == ST_ISSUE);
    assign w_resp  = (r_state == ST_RESP);

    mem_arb_pick #(
        .DBG_MAX (DBG_MAX)
    ) u_pick (
        .clk       (clk),
        .rst       (rst),
        .i_arb     (w_idle),
        .i_d_req   (d_req),
        .i_if_req  (if_req),
        .i_dbg_req (dbg_req),
        .o_id      (w_id),
        .o_any     (w_any)
    );

    // Route the winner's request fields to the latch registers; IF only reads
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = if_addr;
        w_sel_wdata = '0;
        case (w_id)
            REQ_D: begin
                w_sel_we    = d_we;
                w_sel_addr  = d_addr;
                w_sel_wdata = d_wdata;
            end
            REQ_DBG: begin
                w_sel_we    = dbg_we;
                w_sel_addr  = dbg_addr;
                w_sel_wdata = dbg_wdata;
            end
            default: begin
                w_sel_we    = 1'b0;
                w_sel_addr  = if_addr;
                w_sel_wdata = '0;
            end
        endcase
    end

    // One access at a time: arbitrate, issue, wait out read latency, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_id        <= REQ_D;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_lat       <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_dbg_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_id;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_lat   <= LW'(MEM_LAT);
                    r_state <= r_we ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat == LW'(1)) begin
                        case (r_id)
                            REQ_D:   r_d_rdata   <= mem_rdata;
                            REQ_IF:  r_if_rdata  <= mem_rdata;
                            default: r_dbg_rdata <= mem_rdata;
                        endcase
                        r_state <= ST_RESP;
                    end else begin
                        r_lat <= r_lat - LW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = w_issue;
    assign mem_we    = w_issue & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign d_gnt     = w_issue && (r_id == REQ_D);
    assign if_gnt    = w_issue && (r_id == REQ_IF);
    assign dbg_gnt   = w_issue && (r_id == REQ_DBG);
    assign d_valid   = w_resp && (r_id == REQ_D);
    assign if_valid  = w_resp && (r_id == REQ_IF);
    assign dbg_valid = w_resp && (r_id == REQ_DBG);

    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed checks of the memory port arbiter
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Instance A: MEM_LAT=1, DBG_MAX=2
    logic        a_if_req = 0, a_if_gnt, a_if_valid;
    logic [31:0] a_if_addr = 0, a_if_rdata;
    logic        a_d_req = 0, a_d_we = 0, a_d_gnt, a_d_valid;
    logic [31:0] a_d_addr = 0, a_d_wdata = 0, a_d_rdata;
    logic        a_dbg_req = 0, a_dbg_we = 0, a_dbg_gnt, a_dbg_valid;
    logic [31:0] a_dbg_addr = 0, a_dbg_wdata = 0, a_dbg_rdata;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    // Instance B: MEM_LAT=3, DBG_MAX=8
    logic        b_if_req = 0, b_if_gnt, b_if_valid;
    logic [31:0] b_if_addr = 0, b_if_rdata;
    logic        b_d_req = 0, b_d_we = 0, b_d_gnt, b_d_valid;
    logic [31:0] b_d_addr = 0, b_d_wdata = 0, b_d_rdata;
    logic        b_dbg_req = 0, b_dbg_we = 0, b_dbg_gnt, b_dbg_valid;
    logic [31:0] b_dbg_addr = 0, b_dbg_wdata = 0, b_dbg_rdata;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .DBG_MAX(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rdata(a_if_rdata), .if_valid(a_if_valid),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rdata(a_d_rdata), .d_valid(a_d_valid),
        .dbg_req(a_dbg_req), .dbg_we(a_dbg_we), .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata),
        .dbg_gnt(a_dbg_gnt), .dbg_rdata(a_dbg_rdata), .dbg_valid(a_dbg_valid),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .DBG_MAX(8)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rdata(b_d_rdata), .d_valid(b_d_valid),
        .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
        .dbg_gnt(b_dbg_gnt), .dbg_rdata(b_dbg_rdata), .dbg_valid(b_dbg_valid),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    // Memory models: word array, read data MEM_LAT cycles after mem_en
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] pa;
    logic [31:0] pb [0:2];

    assign a_mem_rdata = pa;
    assign b_mem_rdata = pb[2];

    always @(posedge clk) begin
        if (preload) begin
            mem_a[4]  <= 32'hE3A01005;
            mem_a[17] <= 32'h11112222;
            mem_a[18] <= 32'h5A5A0001;
            pa        <= 32'h0;
        end else begin
            if (a_mem_en && a_mem_we) mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
            pa <= a_mem_en ? mem_a[a_mem_addr[9:2]] : 32'hBADBAD00;
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            mem_b[4]  <= 32'hE3A01005;
            mem_b[32] <= 32'hCAFEF00D;
            mem_b[33] <= 32'h12345678;
            pb[0] <= 32'h0;
            pb[1] <= 32'h0;
            pb[2] <= 32'h0;
        end else begin
            if (b_mem_en && b_mem_we) mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
            pb[0] <= b_mem_en ? mem_b[b_mem_addr[9:2]] : 32'hBADBAD00;
            pb[1] <= pb[0];
            pb[2] <= pb[1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int ng;
    logic [1:0] gid [0:3];

    initial begin
        // Reset
        tick(); tick();
        chk("rst_a_gnt", {a_if_gnt, a_d_gnt, a_dbg_gnt}, 0);
        chk("rst_a_valid", {a_if_valid, a_d_valid, a_dbg_valid}, 0);
        chk("rst_a_mem", {a_mem_en, a_mem_we}, 0);
        chk("rst_a_addr", a_mem_addr, 0);
        chk("rst_a_wdata", a_mem_wdata, 0);
        chk("rst_a_rdata", a_if_rdata | a_d_rdata | a_dbg_rdata, 0);
        chk("rst_b_any", {b_if_gnt, b_d_gnt, b_dbg_gnt, b_if_valid, b_d_valid, b_dbg_valid, b_mem_en}, 0);
        preload = 1'b0;
        rst = 1'b0;
        tick();

        // Test 1: IF read, MEM_LAT=1
        a_if_req = 1; a_if_addr = 32'h10;
        tick();
        chk("t1_if_gnt", a_if_gnt, 1);
        chk("t1_mem_en", a_mem_en, 1);
        chk("t1_mem_addr", a_mem_addr, 32'h10);
        chk("t1_mem_we", a_mem_we, 0);
        a_if_req = 0;
        tick();
        chk("t1_c2_quiet", {a_if_gnt, a_if_valid, a_mem_en}, 0);
        tick();
        chk("t1_if_valid", a_if_valid, 1);
        chk("t1_if_rdata", a_if_rdata, 32'hE3A01005);
        chk("t1_no_gnt_with_valid", a_if_gnt, 0);
        tick();
        chk("t1_valid_pulse", a_if_valid, 0);
        chk("t1_rdata_hold", a_if_rdata, 32'hE3A01005);

        // Test 2: D store beats IF
        a_d_req = 1; a_d_we = 1; a_d_addr = 32'h40; a_d_wdata = 32'hDEADBEEF;
        a_if_req = 1; a_if_addr = 32'h44;
        tick();
        chk("t2_d_gnt", a_d_gnt, 1);
        chk("t2_if_gnt_c1", a_if_gnt, 0);
        chk("t2_mem_we", a_mem_we, 1);
        chk("t2_mem_addr", a_mem_addr, 32'h40);
        chk("t2_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
        a_d_req = 0; a_d_we = 0;
        tick();
        chk("t2_d_valid", a_d_valid, 1);
        tick();
        chk("t2_if_gnt_c3", a_if_gnt, 0);
        tick();
        chk("t2_if_gnt_c4", a_if_gnt, 1);
        a_if_req = 0;
        tick(); tick();
        chk("t2_if_valid", a_if_valid, 1);
        chk("t2_if_rdata", a_if_rdata, 32'h11112222);
        chk("t2_d_rdata_store", a_d_rdata, 0);
        tick();
        // Read back the stored word through D
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h40;
        tick();
        chk("t2_rb_gnt", a_d_gnt, 1);
        a_d_req = 0;
        tick(); tick();
        chk("t2_rb_valid", a_d_valid, 1);
        chk("t2_rb_rdata", a_d_rdata, 32'hDEADBEEF);
        tick();

        // Test 3: DBG starvation promotion, DBG_MAX=2
        a_dbg_req = 1; a_dbg_we = 0; a_dbg_addr = 32'h48;
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h40;
        a_if_req = 1; a_if_addr = 32'h10;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (a_d_gnt || a_if_gnt || a_dbg_gnt) begin
                chk("t3_onehot", 32'(a_d_gnt) + 32'(a_if_gnt) + 32'(a_dbg_gnt), 1);
                gid[ng] = a_dbg_gnt ? 2'd2 : (a_if_gnt ? 2'd1 : 2'd0);
                ng++;
            end
        end
        a_dbg_req = 0; a_d_req = 0; a_if_req = 0;
        chk("t3_grant_count", ng, 4);
        chk("t3_g0", 32'(gid[0]), 0);
        chk("t3_g1", 32'(gid[1]), 0);
        chk("t3_g2_dbg", 32'(gid[2]), 2);
        chk("t3_g3_cleared", 32'(gid[3]), 0);
        chk("t3_dbg_rdata", a_dbg_rdata, 32'h5A5A0001);
        tick(); tick(); tick();

        // Test 4: MEM_LAT=3 load
        b_d_req = 1; b_d_we = 0; b_d_addr = 32'h80;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin
                chk("t4_d_gnt", b_d_gnt, 1);
                b_d_req = 0;
            end
            chk($sformatf("t4_d_valid_c%0d", c), b_d_valid, (c == 5) ? 1 : 0);
        end
        chk("t4_d_rdata", b_d_rdata, 32'hCAFEF00D);
        b_if_req = 1; b_if_addr = 32'h10;
        tick();
        b_if_req = 0;
        tick(); tick(); tick(); tick();
        chk("t4_b_if_valid", b_if_valid, 1);
        chk("t4_b_if_rdata", b_if_rdata, 32'hE3A01005);
        chk("t4_hold_after_if", b_d_rdata, 32'hCAFEF00D);
        tick();
        b_d_req = 1; b_d_we = 1; b_d_addr = 32'h88; b_d_wdata = 32'h00000001;
        tick();
        b_d_req = 0; b_d_we = 0;
        tick();
        chk("t4_store_valid", b_d_valid, 1);
        tick();
        chk("t4_hold_after_store", b_d_rdata, 32'hCAFEF00D);

        // Test 5: reset during WAIT
        b_d_req = 1; b_d_we = 0; b_d_addr = 32'h84;
        tick();
        b_d_req = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("t5_gnt_valid", {b_d_gnt, b_d_valid, b_if_gnt, b_if_valid}, 0);
        chk("t5_mem", {b_mem_en, b_mem_we}, 0);
        chk("t5_mem_addr", b_mem_addr, 0);
        chk("t5_d_rdata", b_d_rdata, 0);
        chk("t5_if_rdata", b_if_rdata, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t5_no_late_valid", {b_d_valid, b_mem_en}, 0);
        end
        chk("t5_d_rdata_late", b_d_rdata, 0);
        b_if_req = 1; b_if_addr = 32'h10;
        tick();
        chk("t5_if_gnt", b_if_gnt, 1);
        b_if_req = 0;
        tick(); tick(); tick(); tick();
        chk("t5_if_valid", b_if_valid, 1);
        chk("t5_if_rdata", b_if_rdata, 32'hE3A01005);

        // Test 6: IF request absent for one IDLE cycle
        a_if_req = 0;
        tick();
        chk("t6_no_gnt", {a_if_gnt, a_mem_en}, 0);
        a_if_req = 1; a_if_addr = 32'h44;
        tick();
        chk("t6_if_gnt", a_if_gnt, 1);
        a_if_req = 0;
        tick(); tick();
        chk("t6_if_valid", a_if_valid, 1);
        chk("t6_if_rdata", a_if_rdata, 32'h11112222);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
